// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types for the memory read-channel arbiter: FSM state encoding and
// requester identifiers, plus a small helper used by the round-robin picker.
package mem_rd_arbiter_pkg;

    // One-hot controller states
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        MEM_REQ = 3'b010,
        MEM_RSP = 3'b100
    } state_e;

    // Requester identifiers
    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } req_id_e;

    // The requester that is not 'id'
    function automatic req_id_e other_req(input req_id_e id);
        req_id_e res;
        if (id == REQ_ICACHE) begin
            res = REQ_DCACHE;
        end else begin
            res = REQ_ICACHE;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Read channel bundle: a request (address) handshake and a burst response
// handshake. The master issues requests and consumes beats; the slave
// accepts requests and produces beats.
interface mem_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input round-robin picker. Purely combinational: a lone requester
// always wins; on a tie the requester that did not win last time wins.
// Bit 0 of req is the I-cache, bit 1 the D-cache.
module rr_arb2
    import mem_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    output logic       gnt_valid,
    output req_id_e    winner
);

    // Select the winner from the current requests and the previous grant
    always_comb begin
        gnt_valid = 1'b0;
        winner    = REQ_ICACHE;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                winner    = REQ_ICACHE;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                winner    = REQ_DCACHE;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                winner    = other_req(last_grant);
            end
            default: begin
                gnt_valid = 1'b0;
                winner    = REQ_ICACHE;
            end
        endcase
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Read-channel arbiter between the I-cache and D-cache miss ports and one
// shared memory read port. One burst is in flight at a time; its beats are
// passed straight through to the granted requester. A sticky flag records
// any burst whose beat count differed from BURST_LEN.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_rd_arbiter_if.slave         icache,
    mem_rd_arbiter_if.slave         dcache,
    mem_rd_arbiter_if.master        mem,
    output logic                    proto_err
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W:0] BURST_LEN_W = (CNT_W + 1)'(BURST_LEN);

    state_e              state_r,      state_nxt;
    req_id_e             grant_r,      grant_nxt;
    req_id_e             last_grant_r, last_grant_nxt;
    logic [CNT_W-1:0]    beat_cnt_r,   beat_cnt_nxt;
    logic                proto_err_r,  proto_err_nxt;
    logic [ADDR_W-1:0]   addr_r,       addr_nxt;

    logic                arb_valid_s;
    req_id_e             arb_winner_s;
    logic [CNT_W:0]      cnt_inc_s;
    logic                own_rsp_ready_s;
    logic                beat_fire_s;

    rr_arb2 u_rr_arb2 (
        .req        ({dcache.req_valid, icache.req_valid}),
        .last_grant (last_grant_r),
        .gnt_valid  (arb_valid_s),
        .winner     (arb_winner_s)
    );

    assign proto_err = proto_err_r;

    // Controller state and burst bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            grant_r      <= REQ_ICACHE;
            last_grant_r <= REQ_DCACHE;
            beat_cnt_r   <= {CNT_W{1'b0}};
            proto_err_r  <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_nxt;
            grant_r      <= grant_nxt;
            last_grant_r <= last_grant_nxt;
            beat_cnt_r   <= beat_cnt_nxt;
            proto_err_r  <= proto_err_nxt;
            addr_r       <= addr_nxt;
        end
    end

    // Next-state logic, handshake outputs and beat routing
    always_comb begin
        state_nxt      = state_r;
        grant_nxt      = grant_r;
        last_grant_nxt = last_grant_r;
        beat_cnt_nxt   = beat_cnt_r;
        proto_err_nxt  = proto_err_r;
        addr_nxt       = addr_r;

        icache.req_ready = 1'b0;
        icache.rsp_valid = 1'b0;
        icache.rsp_last  = 1'b0;
        icache.rsp_data  = mem.rsp_data;
        dcache.req_ready = 1'b0;
        dcache.rsp_valid = 1'b0;
        dcache.rsp_last  = 1'b0;
        dcache.rsp_data  = mem.rsp_data;
        mem.req_valid    = 1'b0;
        mem.req_addr     = addr_r;
        mem.rsp_ready    = 1'b0;

        cnt_inc_s   = {1'b0, beat_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        beat_fire_s = 1'b0;
        if (grant_r == REQ_ICACHE) begin
            own_rsp_ready_s = icache.rsp_ready;
        end else begin
            own_rsp_ready_s = dcache.rsp_ready;
        end

        case (state_r)
            IDLE: begin
                // The readies are combinational from valid, so they are
                // gated by reset to stay low while reset is asserted.
                if (rst && arb_valid_s) begin
                    grant_nxt = arb_winner_s;
                    state_nxt = MEM_REQ;
                    if (arb_winner_s == REQ_ICACHE) begin
                        icache.req_ready = 1'b1;
                        addr_nxt         = icache.req_addr;
                    end else begin
                        dcache.req_ready = 1'b1;
                        addr_nxt         = dcache.req_addr;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            MEM_REQ: begin
                mem.req_valid = 1'b1;
                if (mem.req_ready) begin
                    state_nxt    = MEM_RSP;
                    beat_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    state_nxt = MEM_REQ;
                end
            end
            MEM_RSP: begin
                mem.rsp_ready = own_rsp_ready_s;
                if (grant_r == REQ_ICACHE) begin
                    icache.rsp_valid = mem.rsp_valid;
                    icache.rsp_last  = mem.rsp_last;
                end else begin
                    dcache.rsp_valid = mem.rsp_valid;
                    dcache.rsp_last  = mem.rsp_last;
                end
                beat_fire_s = mem.rsp_valid && own_rsp_ready_s;
                if (beat_fire_s) begin
                    // Saturate so an overlong burst cannot wrap back to a
                    // count that looks correct at its last beat.
                    if (cnt_inc_s[CNT_W]) begin
                        beat_cnt_nxt = beat_cnt_r;
                    end else begin
                        beat_cnt_nxt = cnt_inc_s[CNT_W-1:0];
                    end
                    if (mem.rsp_last) begin
                        if (cnt_inc_s != BURST_LEN_W) begin
                            proto_err_nxt = 1'b1;
                        end else begin
                            proto_err_nxt = proto_err_r;
                        end
                        last_grant_nxt = grant_r;
                        state_nxt      = IDLE;
                    end else if (cnt_inc_s > BURST_LEN_W) begin
                        proto_err_nxt = 1'b1;
                        state_nxt     = MEM_RSP;
                    end else begin
                        state_nxt = MEM_RSP;
                    end
                end else begin
                    state_nxt = MEM_RSP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Randomised scoreboard bench for mem_rd_arbiter. A behavioural model
// (round-robin order, beat data derived from the address) fills expectation
// queues at stimulus time; a memory model and per-requester monitors pop
// and compare as the DUT presents requests and beats.
module tb_mem_rd_arbiter;

    typedef struct {
        int          id;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic proto_err;

    mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ic_if ();
    mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dc_if ();
    mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .icache    (ic_if),
        .dcache    (dc_if),
        .mem       (mem_if),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    req_t  exp_req_q[$];
    beat_t exp_ic_q[$];
    beat_t exp_dc_q[$];
    int    model_last = 1;
    bit    exp_proto_err = 1'b0;
    int    mem_req_delay = 0;
    int    mem_len = 8;
    bit    mem_gap_en = 1'b0;
    bit    mem_busy = 1'b0;
    int    rdy_mode[2];
    int    pat_cnt[2];
    int    ic_beats = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
        return (a << 8) | ((32'(i) * 32'h0000_0011) & 32'h0000_00FF);
    endfunction

    // ---------------- reference model ----------------
    function automatic void push_burst(input int id, input logic [31:0] a, input int len);
        req_t  r;
        beat_t b;
        r.id = id;
        r.addr = a;
        exp_req_q.push_back(r);
        for (int i = 1; i <= len; i++) begin
            b.data = beat_data(a, i);
            b.last = (i == len);
            if (id == 0) exp_ic_q.push_back(b);
            else         exp_dc_q.push_back(b);
        end
        if (len != 8) exp_proto_err = 1'b1;
    endfunction

    function automatic void model_single(input int id, input logic [31:0] a);
        push_burst(id, a, mem_len);
        model_last = id;
    endfunction

    function automatic void model_pair(input logic [31:0] ai, input logic [31:0] ad);
        int w;
        w = 1 - model_last;
        push_burst(w, (w == 0) ? ai : ad, mem_len);
        push_burst(1 - w, (w == 0) ? ad : ai, mem_len);
        model_last = 1 - w;
    endfunction

    // ---------------- requester side ----------------
    function automatic logic next_rdy(input int id);
        logic [3:0] pat;
        logic       r;
        pat = 4'b1001;
        case (rdy_mode[id])
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = pat[pat_cnt[id] % 4];
        endcase
        pat_cnt[id]++;
        return r;
    endfunction

    initial begin
        ic_if.rsp_ready = 1'b0;
        dc_if.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ic_if.rsp_ready = next_rdy(0);
            dc_if.rsp_ready = next_rdy(1);
        end
    end

    task automatic issue(input int id, input logic [31:0] a);
        int   g;
        logic rdy;
        @(posedge clk);
        #1;
        if (id == 0) begin ic_if.req_valid = 1'b1; ic_if.req_addr = a; end
        else         begin dc_if.req_valid = 1'b1; dc_if.req_addr = a; end
        g = 0;
        do begin
            @(negedge clk);
            g++;
            rdy = (id == 0) ? ic_if.req_ready : dc_if.req_ready;
        end while (!rdy && g < 500);
        chk("req_accept_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) ic_if.req_valid = 1'b0;
        else         dc_if.req_valid = 1'b0;
    endtask

    // Response monitors: pop an expected beat on every accepted beat
    always @(negedge clk) begin
        beat_t e;
        if (rst && ic_if.rsp_valid && ic_if.rsp_ready) begin
            ic_beats++;
            if (exp_ic_q.size() == 0) chk("icache_unexpected_beat", 32'd1, 32'd0);
            else begin
                e = exp_ic_q.pop_front();
                chk("icache_beat_data", ic_if.rsp_data, e.data);
                chk("icache_beat_last", 32'(ic_if.rsp_last), 32'(e.last));
            end
        end
        if (rst && dc_if.rsp_valid && dc_if.rsp_ready) begin
            if (exp_dc_q.size() == 0) chk("dcache_unexpected_beat", 32'd1, 32'd0);
            else begin
                e = exp_dc_q.pop_front();
                chk("dcache_beat_data", dc_if.rsp_data, e.data);
                chk("dcache_beat_last", 32'(dc_if.rsp_last), 32'(e.last));
            end
        end
    end

    // ---------------- memory model / request monitor ----------------
    task automatic mem_abort();
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_last  = 1'b0;
        mem_if.req_ready = 1'b0;
        mem_busy = 1'b0;
        wait (rst == 1'b1);
    endtask

    task automatic beat_checks(input int owner);
        logic own_rdy;
        own_rdy = (owner == 0) ? ic_if.rsp_ready : dc_if.rsp_ready;
        chk("rsp_ready_mirror", 32'(mem_if.rsp_ready), 32'(own_rdy));
        if (owner == 0) chk("non_owner_quiet", 32'({dc_if.rsp_valid, dc_if.rsp_last}), 32'd0);
        else            chk("non_owner_quiet", 32'({ic_if.rsp_valid, ic_if.rsp_last}), 32'd0);
        chk("single_mem_req", 32'(mem_if.req_valid), 32'd0);
    endtask

    task automatic mem_serve();
        logic [31:0] cap;
        int          cyc, owner, len_now, guard;
        logic        fired;
        req_t        e;
        do begin
            @(posedge clk);
            #1;
            mem_if.req_ready = (mem_req_delay == 0);
            @(negedge clk);
        end while (!(rst && mem_if.req_valid));
        mem_busy = 1'b1;
        cap = mem_if.req_addr;
        cyc = 1;
        while (!mem_if.req_ready) begin
            if (cyc >= mem_req_delay) begin
                @(posedge clk);
                #1;
                mem_if.req_ready = 1'b1;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
            if (!rst) begin mem_abort(); return; end
            chk("mem_req_valid_hold", 32'(mem_if.req_valid), 32'd1);
            chk("mem_req_addr_hold", mem_if.req_addr, cap);
            cyc++;
        end
        chk("mem_req_valid_cycles", 32'(cyc), 32'(mem_req_delay + 1));
        @(posedge clk);
        #1;
        mem_if.req_ready = (mem_req_delay == 0);
        owner = 0;
        if (exp_req_q.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
        else begin
            e = exp_req_q.pop_front();
            chk("mem_req_addr", cap, e.addr);
            owner = e.id;
        end
        len_now = mem_len;
        for (int i = 1; i <= len_now; i++) begin
            if (mem_gap_en) begin
                mem_if.rsp_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                if (!rst) begin mem_abort(); return; end
            end
            mem_if.rsp_valid = 1'b1;
            mem_if.rsp_data  = beat_data(cap, i);
            mem_if.rsp_last  = (i == len_now);
            fired = 1'b0;
            guard = 0;
            while (!fired) begin
                @(negedge clk);
                if (!rst) begin mem_abort(); return; end
                beat_checks(owner);
                fired = mem_if.rsp_ready;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 200) begin
                    chk("beat_accept_timeout", 32'd1, 32'd0);
                    mem_abort();
                    return;
                end
            end
        end
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_last  = 1'b0;
        mem_busy = 1'b0;
    endtask

    initial begin
        mem_if.req_ready = 1'b0;
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_data  = 32'd0;
        mem_if.rsp_last  = 1'b0;
        forever mem_serve();
    end

    // ---------------- sequencing helpers ----------------
    task automatic quiet_checks(input string tag);
        chk({tag, "_icache_req_ready"}, 32'(ic_if.req_ready), 32'd0);
        chk({tag, "_dcache_req_ready"}, 32'(dc_if.req_ready), 32'd0);
        chk({tag, "_icache_rsp_valid"}, 32'(ic_if.rsp_valid), 32'd0);
        chk({tag, "_dcache_rsp_valid"}, 32'(dc_if.rsp_valid), 32'd0);
        chk({tag, "_mem_req_valid"}, 32'(mem_if.req_valid), 32'd0);
        chk({tag, "_mem_rsp_ready"}, 32'(mem_if.rsp_ready), 32'd0);
        chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while ((exp_req_q.size() != 0 || exp_ic_q.size() != 0 || exp_dc_q.size() != 0 || mem_busy)
               && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_drain_timeout"}, 32'(g < 3000), 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_proto_err"}, 32'(proto_err), 32'(exp_proto_err));
    endtask

    task automatic run_pair(input logic [31:0] ai, input logic [31:0] ad);
        model_pair(ai, ad);
        fork
            issue(0, ai);
            issue(1, ad);
        join
    endtask

    task automatic run_single(input int id, input logic [31:0] a);
        model_single(id, a);
        issue(id, a);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int          base, g, sel;
        logic [31:0] ra, rd;
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        ic_if.req_valid = 1'b0;
        ic_if.req_addr  = 32'd0;
        dc_if.req_valid = 1'b0;
        dc_if.req_addr  = 32'd0;
        #2;
        rst = 1'b0;
        ic_if.req_valid = 1'b1;
        dc_if.req_valid = 1'b1;
        #1;
        quiet_checks("reset");
        ic_if.req_valid = 1'b0;
        dc_if.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_pair(32'h0000_2000, 32'h8000_0040);
        drain("pair_after_reset");
        run_single(0, 32'h0000_1000);
        drain("single_icache");
        run_pair(32'h0000_3000, 32'h0000_4020);
        drain("pair_second");

        mem_req_delay = 5;
        run_single(0, 32'h0000_6000);
        drain("mem_req_stall");
        mem_req_delay = 0;

        rdy_mode[0] = 2;
        run_single(0, 32'h0000_7000);
        drain("rsp_ready_toggle");
        rdy_mode[0] = 0;

        for (int it = 0; it < 20; it++) begin
            mem_req_delay = $urandom_range(0, 3);
            mem_gap_en    = 1'($urandom_range(0, 1));
            rdy_mode[0]   = $urandom_range(0, 1);
            rdy_mode[1]   = $urandom_range(0, 1);
            ra  = $urandom() & 32'hFFFF_FFE0;
            rd  = $urandom() & 32'hFFFF_FFE0;
            sel = $urandom_range(0, 2);
            if (sel < 2) run_single(sel, (sel == 0) ? ra : rd);
            else         run_pair(ra, rd);
            drain("random");
        end
        mem_req_delay = 0;
        mem_gap_en    = 1'b0;
        rdy_mode[0]   = 0;
        rdy_mode[1]   = 0;

        mem_len = 6;
        run_single(0, 32'h0000_9000);
        drain("short_burst");
        mem_len = 8;
        run_single(1, 32'h0000_9020);
        drain("sticky_after_good");

        run_single(0, 32'h0000_A000);
        base = ic_beats;
        g = 0;
        while (ic_beats < base + 3 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("midburst_wait_timeout", 32'(g < 200), 32'd1);
        #2;
        rst = 1'b0;
        dc_if.req_valid = 1'b1;
        dc_if.req_addr  = 32'h0000_0E00;
        #1;
        quiet_checks("midburst_reset");
        exp_req_q.delete();
        exp_ic_q.delete();
        exp_dc_q.delete();
        exp_proto_err = 1'b0;
        model_last = 1;
        repeat (3) @(negedge clk);
        dc_if.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_single(0, 32'h0000_B000);
        drain("after_reset");

        mem_len = 10;
        run_single(1, 32'h0000_C000);
        drain("long_burst");
        mem_len = 8;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
